logic_sequencer: RTL and testbench
==================================

# logic_sequencer

Multi-cycle control sequencer for the LEGv8 logical instruction group: AND, ORR, EOR, ANDS (R-format) and ANDI, ORRI, EORI, ANDIS (I-format). It accepts one 32-bit instruction through a valid/ready handshake, holds it, and drives the datapath control fields for a configurable number of execute cycles followed by one write-back cycle. It sits between the fetch stage and the register file/ALU, and replaces the purely combinational logic decoder.

## Interface
Parameters:
- DATA_WIDTH, 64: width of the datapath and of `k`; must be ≥ 12.
- EXEC_CYCLES, 1: number of EXEC cycles per instruction; must be ≥ 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word.
- instr_valid  in  1  `instr` is valid.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- DA, SA, SB  out  5 each  destination, source A and source B register numbers.
- FS  out  5  ALU function select.
- PS  out  2  PC select.
- enable  out  2  data-bus source select.
- regWrite, memWrite  out  1 each  register-file and memory write enables.
- PC_sel, B_sel  out  1 each  PC source select; ALU B-input immediate select.
- status_load  out  1  load the NZCV flags.
- k  out  DATA_WIDTH  immediate constant.
- state  out  2  current state.
- done  out  1  one-cycle pulse in WB.
- illegal  out  1  one-cycle pulse on an unsupported instruction.

## Operation
- States are encoded as IDLE=00, EXEC=01, WB=10, TRAP=11.
- IDLE: `instr_ready`=1. All control outputs are 0 and `k`=0. On `instr_valid`&&`instr_ready`, latch `instr` and classify it.
- I-format decode uses `opcode = instr[31:22]`:
  - ANDI=1001001000, ORRI=1011001000, EORI=1101001000, ANDIS=1111001000.
- R-format decode uses `opcode = instr[31:21]`:
  - AND=10001010000, ORR=10101010000, EOR=11001010000, ANDS=11101010000.
- An R-format instruction with a nonzero shamt `instr[15:10]` is illegal. Any opcode not listed is illegal.
- Legal instruction: next state EXEC, with the cycle counter loaded to 0.
- Illegal instruction: next state TRAP.
- Control fields are derived from the latched instruction and are held constant through EXEC and WB:
  - `DA` = `instr[4:0]` (Rd). `SA` = `instr[9:5]` (Rn).
  - `SB` = `instr[20:16]` (Rm) for R-format; 0 for I-format.
  - `FS`: AND family = 00000, ORR family = 00100, EOR family = 01100.
  - `B_sel` = 1 for I-format, 0 for R-format.
  - `k`: for I-format, `instr[21:10]` zero-extended to DATA_WIDTH; 0 for R-format.
  - `enable` = 01 (ALU drives the bus). `memWrite` = 0 and `PC_sel` = 0 always.
- EXEC: the counter increments each cycle. When the counter reaches EXEC_CYCLES−1, the next state is WB. `PS` = 00 and `regWrite` = 0.
- WB, one cycle:
  - `regWrite` = 1, unless Rd = 31 (XZR), in which case `regWrite` = 0.
  - `status_load` = 1 only for ANDS and ANDIS.
  - `PS` = 01 (PC+4). `done` = 1. Next state IDLE.
- TRAP, one cycle:
  - `illegal` = 1 and `PS` = 01.
  - All other controls are 0, including `regWrite` and `status_load`.
  - Next state IDLE.
- `instr` and `instr_valid` are ignored outside IDLE.

## Timing
- Reset asserted (low): state goes to IDLE immediately and asynchronously. The counter is cleared, the latched instruction is cleared, and all outputs are 0 except `instr_ready`=1.
- Reset mid-EXEC or mid-WB: the instruction is dropped with no `regWrite`, `status_load` or `done`.
- Handshake accepted at edge t0, legal instruction:
  - EXEC occupies cycles t0+1 … t0+EXEC_CYCLES.
  - WB occupies cycle t0+EXEC_CYCLES+1.
  - IDLE (`instr_ready`=1) resumes at t0+EXEC_CYCLES+2.
- Handshake accepted at edge t0, illegal instruction: TRAP at t0+1, IDLE at t0+2.
- Throughput is one instruction per EXEC_CYCLES+2 cycles. There is no overlap between instructions.
- The counter is $clog2(EXEC_CYCLES+1) bits wide and never wraps past EXEC_CYCLES−1.
- All outputs are registered or decoded from registered state only. There is no combinational path from `instr` to any control output.

## Test plan
- Reset: hold `reset`=0 mid-EXEC, then release → `state`=00, `instr_ready`=1, all controls 0, and no `done` follows.
- ANDI, EXEC_CYCLES=1, `instr`=1001001000_000000000001_00000_00001 → then:
  - EXEC one cycle: `FS`=00000, `B_sel`=1, `k`=1, `SA`=0, `DA`=1.
  - WB: `regWrite`=1, `status_load`=0, `PS`=01, `done`=1.
- ANDS with EXEC_CYCLES=3, `instr`=11101010000_00011_000000_10000_00100 → then:
  - EXEC lasts 3 cycles: `SB`=3, `SA`=16, `DA`=4, `B_sel`=0.
  - WB: `status_load`=1. `instr_ready` returns at t0+5.
- EORI writing XZR, `instr`=1101001000_000000000100_00100_11111 → `FS`=01100, `k`=4; in WB `regWrite`=0 and `done`=1.
- Illegal inputs:
  - ORR with shamt=000001 → TRAP one cycle, `illegal`=1, `regWrite`=0.
  - Opcode 0xFFFFFFFF → same TRAP response.
- Back-to-back instructions with `instr_valid` held high → the second instruction is accepted only once `instr_ready` returns. An `instr` change during EXEC does not alter `DA`/`SA`/`SB`/`FS`/`k`.

Source files
------------

// File: rtl/logic_sequencer.sv
// Multi-cycle control sequencer for the LEGv8 logical group (AND/ORR/EOR/ANDS and immediates).
// One instruction per handshake: EXEC_CYCLES execute cycles, one write-back cycle, no overlap.
module logic_sequencer #(
    parameter int DATA_WIDTH  = 64,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [4:0]            DA,
    output logic [4:0]            SA,
    output logic [4:0]            SB,
    output logic [4:0]            FS,
    output logic [1:0]            PS,
    output logic [1:0]            enable,
    output logic                  regWrite,
    output logic                  memWrite,
    output logic                  PC_sel,
    output logic                  B_sel,
    output logic                  status_load,
    output logic [DATA_WIDTH-1:0] k,
    output logic [1:0]            state,
    output logic                  done,
    output logic                  illegal
);

    // state | meaning
    // IDLE  | instr_ready high, waiting for a handshake; all controls 0
    // EXEC  | controls driven from the held instruction, counter runs
    // WB    | one cycle: register write (unless XZR), optional flag load, done
    // TRAP  | one cycle: illegal pulse, PC+4, all other controls 0
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WB   = 2'b10,
        S_TRAP = 2'b11
    } state_t;

    localparam int           CW       = $clog2(EXEC_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_CYCLES - 1);

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_EOR = 5'b01100;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          load;

    // Held instruction, reduced to the fields the datapath needs
    logic [4:0]  rd_q, rn_q, rm_q, fs_q;
    logic [11:0] imm_q;
    logic        imm_fmt_q, flags_q;

    logic        dec_legal, dec_imm, dec_flags;
    logic [4:0]  dec_fs;

    always_comb begin
        dec_legal = 1'b0;
        dec_imm   = 1'b0;
        dec_flags = 1'b0;
        dec_fs    = FS_AND;
        case (instr[31:22])
            10'b1001001000: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_fs = FS_AND; end
            10'b1011001000: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_fs = FS_ORR; end
            10'b1101001000: begin dec_legal = 1'b1; dec_imm = 1'b1; dec_fs = FS_EOR; end
            10'b1111001000: begin
                dec_legal = 1'b1; dec_imm = 1'b1; dec_fs = FS_AND; dec_flags = 1'b1;
            end
            default: begin
                // R-format is only legal with a zero shift amount
                case (instr[31:21])
                    11'b10001010000: begin dec_legal = (instr[15:10] == 6'd0); dec_fs = FS_AND; end
                    11'b10101010000: begin dec_legal = (instr[15:10] == 6'd0); dec_fs = FS_ORR; end
                    11'b11001010000: begin dec_legal = (instr[15:10] == 6'd0); dec_fs = FS_EOR; end
                    11'b11101010000: begin
                        dec_legal = (instr[15:10] == 6'd0); dec_fs = FS_AND; dec_flags = 1'b1;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = dec_legal ? S_EXEC : S_TRAP;
                end
            end
            S_EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WB:    state_d = S_IDLE;
            S_TRAP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            rn_q      <= '0;
            rm_q      <= '0;
            fs_q      <= '0;
            imm_q     <= '0;
            imm_fmt_q <= 1'b0;
            flags_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load) begin
                rd_q      <= instr[4:0];
                rn_q      <= instr[9:5];
                rm_q      <= dec_imm ? 5'd0 : instr[20:16];
                fs_q      <= dec_fs;
                imm_q     <= dec_imm ? instr[21:10] : 12'd0;
                imm_fmt_q <= dec_imm;
                flags_q   <= dec_flags;
            end
        end
    end

    // Outputs depend only on registered state, never on instr directly
    always_comb begin
        instr_ready = 1'b0;
        DA          = '0;
        SA          = '0;
        SB          = '0;
        FS          = '0;
        PS          = 2'b00;
        enable      = 2'b00;
        regWrite    = 1'b0;
        memWrite    = 1'b0;
        PC_sel      = 1'b0;
        B_sel       = 1'b0;
        status_load = 1'b0;
        k           = '0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_IDLE: instr_ready = 1'b1;
            S_EXEC, S_WB: begin
                DA       = rd_q;
                SA       = rn_q;
                SB       = rm_q;
                FS       = fs_q;
                B_sel    = imm_fmt_q;
                k[11:0]  = imm_q;
                enable   = 2'b01;
                if (state_q == S_WB) begin
                    PS          = 2'b01;
                    done        = 1'b1;
                    regWrite    = (rd_q != 5'd31);
                    status_load = flags_q;
                end
            end
            S_TRAP: begin
                illegal = 1'b1;
                PS      = 2'b01;
            end
            default: instr_ready = 1'b0;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_logic_sequencer.sv
// Bench for logic_sequencer: two instances (EXEC_CYCLES=1 and 3) on shared stimulus,
// checked by a directed vector table, corner sequences and a transaction-level model.
module tb_logic_sequencer;

    localparam int DW = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;

    logic        rdy1, rw1, mw1, pcs1, bs1, sl1, dn1, il1;
    logic [4:0]  da1, sa1, sb1, fs1;
    logic [1:0]  ps1, en1, st1;
    logic [DW-1:0] k1;
    logic        rdy3, rw3, mw3, pcs3, bs3, sl3, dn3, il3;
    logic [4:0]  da3, sa3, sb3, fs3;
    logic [1:0]  ps3, en3, st3;
    logic [DW-1:0] k3;

    logic [97:0] obs1, obs3;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    logic_sequencer #(.DATA_WIDTH(DW), .EXEC_CYCLES(1)) dut1 (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(rdy1), .DA(da1), .SA(sa1), .SB(sb1), .FS(fs1), .PS(ps1),
        .enable(en1), .regWrite(rw1), .memWrite(mw1), .PC_sel(pcs1), .B_sel(bs1),
        .status_load(sl1), .k(k1), .state(st1), .done(dn1), .illegal(il1)
    );

    logic_sequencer #(.DATA_WIDTH(DW), .EXEC_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(rdy3), .DA(da3), .SA(sa3), .SB(sb3), .FS(fs3), .PS(ps3),
        .enable(en3), .regWrite(rw3), .memWrite(mw3), .PC_sel(pcs3), .B_sel(bs3),
        .status_load(sl3), .k(k3), .state(st3), .done(dn3), .illegal(il3)
    );

    assign obs1 = {st1, rdy1, da1, sa1, sb1, fs1, ps1, en1, rw1, mw1, pcs1, bs1, sl1, dn1, il1, k1};
    assign obs3 = {st3, rdy3, da3, sa3, sb3, fs3, ps3, en3, rw3, mw3, pcs3, bs3, sl3, dn3, il3, k3};

    function automatic logic [97:0] mk(input logic [1:0] st, input logic rdy,
                                       input logic [4:0] da, input logic [4:0] sa,
                                       input logic [4:0] sb, input logic [4:0] fs,
                                       input logic [1:0] ps, input logic [1:0] en,
                                       input logic rw, input logic bs, input logic sl,
                                       input logic dn, input logic il, input logic [DW-1:0] kk);
        return {st, rdy, da, sa, sb, fs, ps, en, rw, 1'b0, 1'b0, bs, sl, dn, il, kk};
    endfunction

    function automatic logic [97:0] idle_vec();
        return mk(2'd0, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endfunction

    function automatic logic [97:0] trap_vec();
        return mk(2'd3, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    endfunction

    task automatic check(input string name, input logic [97:0] act, input logic [97:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    localparam logic [9:0]  IOPS [4] = '{10'b1001001000, 10'b1011001000, 10'b1101001000, 10'b1111001000};
    localparam logic [10:0] ROPS [4] = '{11'b10001010000, 11'b10101010000, 11'b11001010000, 11'b11101010000};
    localparam logic [4:0]  FSV  [3] = '{5'd0, 5'd4, 5'd12};

    function automatic void classify(input logic [31:0] w, output bit legal, output bit imm,
                                     output int fam, output bit flags);
        legal = 0; imm = 0; fam = 0; flags = 0;
        for (int i = 0; i < 4; i++) begin
            if (w[31:22] == IOPS[i]) begin
                legal = 1; imm = 1; fam = (i == 3) ? 0 : i; flags = (i == 3);
            end
            if (w[31:21] == ROPS[i] && w[15:10] == 6'd0) begin
                legal = 1; imm = 0; fam = (i == 3) ? 0 : i; flags = (i == 3);
            end
        end
    endfunction

    typedef struct packed {
        int          age;     // 0 = idle, otherwise cycles since acceptance
        logic [31:0] held;
        bit          legal;
    } mst_t;

    mst_t m1 = '{age: 0, held: 32'd0, legal: 1'b0};
    mst_t m3 = '{age: 0, held: 32'd0, legal: 1'b0};

    function automatic mst_t adv(input int n, input mst_t m, input logic v, input logic [31:0] w);
        mst_t r;
        bit   imm, flg;
        int   fam;
        r = m;
        if (m.age == 0) begin
            if (v) begin
                r.held = w;
                classify(w, r.legal, imm, fam, flg);
                r.age = 1;
            end
        end else if (m.age == (m.legal ? n + 1 : 1)) begin
            r.age = 0;
        end else begin
            r.age = m.age + 1;
        end
        return r;
    endfunction

    function automatic logic [97:0] model_exp(input int n, input mst_t m);
        bit lg, imm, flg;
        int fam;
        logic [4:0] da, sa, sb;
        logic [DW-1:0] kk;
        if (m.age == 0) return idle_vec();
        if (!m.legal) return trap_vec();
        classify(m.held, lg, imm, fam, flg);
        da = m.held[4:0];
        sa = m.held[9:5];
        sb = imm ? 5'd0 : m.held[20:16];
        kk = imm ? DW'(m.held[21:10]) : '0;
        if (m.age <= n)
            return mk(2'd1, 1'b0, da, sa, sb, FSV[fam], 2'd0, 2'd1, 1'b0, imm, 1'b0, 1'b0, 1'b0, kk);
        return mk(2'd2, 1'b0, da, sa, sb, FSV[fam], 2'd1, 2'd1, (da != 5'd31), imm, flg, 1'b1, 1'b0, kk);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m1 <= '{age: 0, held: 32'd0, legal: 1'b0};
            m3 <= '{age: 0, held: 32'd0, legal: 1'b0};
        end else begin
            m1 <= adv(1, m1, instr_valid, instr);
            m3 <= adv(3, m3, instr_valid, instr);
        end
    end

    always @(negedge clock) begin
        check("model_n1", obs1, model_exp(1, m1));
        check("model_n3", obs3, model_exp(3, m3));
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] w;
        bit          legal;
        logic [4:0]  da, sa, sb, fs;
        bit          bsel;
        logic [11:0] kk;
        bit          rw, sl;
    } vec_t;

    vec_t vt[11];

    function automatic logic [97:0] vec_exp(input vec_t v, input int n, input int c);
        if (!v.legal) return (c == 1) ? trap_vec() : idle_vec();
        if (c <= n)
            return mk(2'd1, 1'b0, v.da, v.sa, v.sb, v.fs, 2'd0, 2'd1, 1'b0, v.bsel, 1'b0, 1'b0, 1'b0, DW'(v.kk));
        if (c == n + 1)
            return mk(2'd2, 1'b0, v.da, v.sa, v.sb, v.fs, 2'd1, 2'd1, v.rw, v.bsel, v.sl, 1'b1, 1'b0, DW'(v.kk));
        return idle_vec();
    endfunction

    task automatic apply_vec(input int idx);
        logic [31:0] rnd;
        @(negedge clock);
        instr = vt[idx].w;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("vec%0d_n1_c%0d", idx, c), obs1, vec_exp(vt[idx], 1, c));
            check($sformatf("vec%0d_n3_c%0d", idx, c), obs3, vec_exp(vt[idx], 3, c));
            rnd = $urandom;
            instr = rnd;
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dn;
        int first_rdy;
        logic [31:0] rnd;

        vt[0]  = '{32'b1001001000_000000000001_00000_00001, 1, 5'd1,  5'd0,  5'd0,  5'd0,  1, 12'd1,   1, 0};
        vt[1]  = '{32'b11101010000_00011_000000_10000_00100, 1, 5'd4,  5'd16, 5'd3,  5'd0,  0, 12'd0,   1, 1};
        vt[2]  = '{32'b1101001000_000000000100_00100_11111, 1, 5'd31, 5'd4,  5'd0,  5'd12, 1, 12'd4,   0, 0};
        vt[3]  = '{32'b10101010000_00010_000001_00011_00101, 0, 5'd0,  5'd0,  5'd0,  5'd0,  0, 12'd0,   0, 0};
        vt[4]  = '{32'hFFFF_FFFF,                            0, 5'd0,  5'd0,  5'd0,  5'd0,  0, 12'd0,   0, 0};
        vt[5]  = '{32'b1011001000_101010101010_00111_01000, 1, 5'd8,  5'd7,  5'd0,  5'd4,  1, 12'hAAA, 1, 0};
        vt[6]  = '{32'b11001010000_11111_000000_00001_00010, 1, 5'd2,  5'd1,  5'd31, 5'd12, 0, 12'd0,   1, 0};
        vt[7]  = '{32'b1111001000_111111111111_11110_00000, 1, 5'd0,  5'd30, 5'd0,  5'd0,  1, 12'hFFF, 1, 1};
        vt[8]  = '{32'b10001010000_00101_000000_00110_00111, 1, 5'd7,  5'd6,  5'd5,  5'd0,  0, 12'd0,   1, 0};
        vt[9]  = '{32'b10001010000_00101_111111_00110_00111, 0, 5'd0,  5'd0,  5'd0,  5'd0,  0, 12'd0,   0, 0};
        vt[10] = '{32'b1001001010_000000000000_00000_00000, 0, 5'd0,  5'd0,  5'd0,  5'd0,  0, 12'd0,   0, 0};

        reset = 1'b0;
        instr = 32'd0;
        instr_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_n1", obs1, idle_vec());
        check("reset_n3", obs3, idle_vec());
        reset = 1'b1;
        @(negedge clock);
        check("post_reset_n3", obs3, idle_vec());

        for (int i = 0; i < 11; i++) apply_vec(i);

        // Reset in the middle of EXEC drops the instruction entirely
        @(negedge clock);
        instr = vt[1].w;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        check("rst_pre_exec", obs3, vec_exp(vt[1], 3, 1));
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check("rst_async_n3", obs3, idle_vec());
        @(negedge clock);
        reset = 1'b1;
        dn = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (dn3 || rw3 || sl3) dn++;
        end
        check_int("rst_no_done", dn, 0);

        // Back-to-back with instr_valid held; instr scrambled while busy
        @(negedge clock);
        instr = vt[0].w;
        instr_valid = 1'b1;
        first_rdy = -1;
        for (int c = 1; c <= 10 && first_rdy < 0; c++) begin
            @(negedge clock);
            if (rdy3) begin
                first_rdy = c;
                instr = vt[6].w;
            end else begin
                check($sformatf("b2b_hold_c%0d", c), obs3, vec_exp(vt[0], 3, c));
                rnd = $urandom;
                instr = rnd;
            end
        end
        check_int("b2b_ready_cycle", first_rdy, 5);
        @(negedge clock);
        instr_valid = 1'b0;
        check("b2b_second", obs3, vec_exp(vt[6], 3, 1));
        repeat (6) @(negedge clock);

        // Randomised traffic, checked by the model at every cycle
        for (int i = 0; i < 600; i++) begin
            int sel;
            int j;
            sel = $urandom_range(0, 3);
            j = $urandom_range(0, 3);
            rnd = $urandom;
            if (sel == 0) begin
                instr = rnd;
            end else if (sel == 1) begin
                instr = {IOPS[j], rnd[21:0]};
            end else begin
                instr = {ROPS[j], rnd[20:0]};
                if ($urandom_range(0, 3) != 0) instr[15:10] = 6'd0;
            end
            instr_valid = ($urandom_range(0, 2) != 0);
            if (i == 300) begin
                #2 reset = 1'b0;
                @(negedge clock);
                reset = 1'b1;
            end
            @(negedge clock);
        end
        instr_valid = 1'b0;
        repeat (6) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
